regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
Shares the single register-file write port (load/sel/data into the 8x16 register bank) between two writeback sources: src0 (ALU/execute) and src1 (memory-load path). Each source has a small FIFO. A round-robin arbiter drains the FIFOs into a registered write port, at one write per cycle. The block also exports a pending-write bitmask that decode uses for RAW hazard stalls.

Parameters:
WIDTH, 16, data width of a register write
NUM_REGS, 8, number of architectural registers; SEL_W = $clog2(NUM_REGS) is derived
DEPTH, 2, entries per source FIFO; must be a power of two and at least 2

Ports:
clk  in  1  system clock; all state in this block updates on the rising edge
reset_n  in  1  asynchronous, active-low reset
src0_valid  in  1  src0 offers a write
src0_ready  out  1  src0 FIFO not full
src0_sel  in  SEL_W  src0 destination register
src0_data  in  WIDTH  src0 write data
src1_valid, src1_ready, src1_sel, src1_data  same as src0, for source 1
flush  in  1  synchronous discard of all queued writes
wr_load  out  1  register-file load enable
wr_sel  out  SEL_W  register-file destination
wr_data  out  WIDTH  register-file write data
pending  out  NUM_REGS  bit r=1 when a write to Rr is queued or being presented
idle  out  1  both FIFOs empty and wr_load=0

Behaviour:
- Reset (reset_n=0, asynchronous): both FIFOs empty, wr_load=0, wr_sel=0, wr_data=0, last-grant pointer=1 so src0 wins the first tie. Outputs after reset: pending=0, idle=1, src*_ready=1.
- Ready: srcN_ready = (countN != DEPTH). It is derived from registered state only; there is no combinational path from valid or grant.
- Push: at each rising edge where srcN_valid && srcN_ready, {sel,data} is appended to FIFO N.
  - A full FIFO does not accept a push even if it pops in the same cycle. There is no pass-through.
- Pop/grant, evaluated each cycle on the FIFO heads before the edge:
  - Neither FIFO non-empty: no grant.
  - Exactly one non-empty: grant that FIFO.
  - Both non-empty: grant the source not granted last; update the last-grant pointer.
- Write port: at the edge, the granted head is popped and registered into wr_sel/wr_data with wr_load=1.
  - With no grant, wr_load=0 and wr_sel/wr_data hold their previous values.
  - wr_load is high for exactly one cycle per entry.
  - The register file captures on the falling edge inside that cycle, so write data is stable half a cycle before capture.
- Latency: a push at edge t into an empty FIFO that wins arbitration gives wr_load=1 in the cycle after edge t+1. Sustained throughput is 1 write/cycle aggregate.
- Simultaneous push and pop on the same FIFO: both take effect and the count is unchanged.
- Ordering: FIFO order is kept within a source. Across sources, order follows grant order only; src0 and src1 writes to the same register may retire in either order, and upstream is responsible for that.
- pending: OR over all valid FIFO entries and the current output (when wr_load=1) of a one-hot decode of sel. It is combinational from registered state.
- flush (synchronous):
  - At the edge, both FIFOs are emptied and wr_load is forced to 0. The last-grant pointer is unchanged.
  - A push in the same cycle as flush is dropped.
  - A write presented in the flush cycle (wr_load=1) still completes at that cycle's falling edge.
- Reset asserted mid-operation: state clears immediately, and any queued writes are lost.
- Counters are log2(DEPTH)+1 bits and pointers wrap modulo DEPTH. No overflow or underflow is possible under the ready/empty guards; the bench asserts on both.

Test Plan:
1. Hold reset_n=0 and then release with no traffic -> wr_load=0, wr_sel=0, wr_data=0, pending=8'h00, idle=1, src0_ready=src1_ready=1.
2. Single src0 push R3=16'h1234 at edge t -> wr_load=1, wr_sel=3, wr_data=16'h1234 for exactly the cycle after edge t+1. pending[3]=1 from after edge t until edge t+2, then 0.
3. Simultaneous push src0 R1=16'hAAAA and src1 R2=16'h5555 straight after reset -> R1 write in cycle t+1, R2 write in cycle t+2, no idle gap. A repeat of the tie then grants src1 first.
4. src0 and src1 both push every cycle for 6 cycles (DEPTH=2) -> writes alternate src0/src1. src*_ready drops to 0 when the count reaches 2, and all 12 entries retire in order within each source with no loss.
5. Two entries queued in src1, one write on the port, and flush=1 with a concurrent src0 push -> the in-flight write completes. After the edge: wr_load=0, pending=0, idle=1. The src0 push never appears on the write port.
6. reset_n pulsed low asynchronously mid-burst (between edges, with FIFOs holding entries) -> wr_load=0, pending=0 and idle=1 immediately. After release, traffic resumes with src0 winning the first tie.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Two-source writeback arbiter for the 8x16 register bank: per-source FIFOs drained
// round-robin into one registered write port, plus a pending-write mask for RAW stalls.
module regfile_wb_arbiter #(
  parameter int  WIDTH    = 16,
  parameter int  NUM_REGS = 8,
  parameter int  DEPTH    = 2,
  localparam int SEL_W    = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                src0_valid,
  output logic                src0_ready,
  input  logic [SEL_W-1:0]    src0_sel,
  input  logic [WIDTH-1:0]    src0_data,
  input  logic                src1_valid,
  output logic                src1_ready,
  input  logic [SEL_W-1:0]    src1_sel,
  input  logic [WIDTH-1:0]    src1_data,
  input  logic                flush,
  output logic                wr_load,
  output logic [SEL_W-1:0]    wr_sel,
  output logic [WIDTH-1:0]    wr_data,
  output logic [NUM_REGS-1:0] pending,
  output logic                idle
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [SEL_W-1:0] sel_mem_q  [2][DEPTH];
  logic [WIDTH-1:0] data_mem_q [2][DEPTH];
  logic [PTR_W-1:0] rd_ptr_q [2];
  logic [PTR_W-1:0] rd_ptr_d [2];
  logic [PTR_W-1:0] wr_ptr_q [2];
  logic [PTR_W-1:0] wr_ptr_d [2];
  logic [CNT_W-1:0] cnt_q    [2];
  logic [CNT_W-1:0] cnt_d    [2];
  logic             last_q, last_d;
  logic             wr_load_q, wr_load_d;
  logic [SEL_W-1:0] wr_sel_q, wr_sel_d;
  logic [WIDTH-1:0] wr_data_q, wr_data_d;

  logic [1:0]          valid_in, ready, nonempty, push, pop;
  logic [SEL_W-1:0]    sel_in    [2];
  logic [WIDTH-1:0]    data_in   [2];
  logic [SEL_W-1:0]    head_sel  [2];
  logic [WIDTH-1:0]    head_data [2];
  logic                grant_any, grant_src;
  logic [NUM_REGS-1:0] pending_v;

  assign valid_in = {src1_valid, src0_valid};

  always_comb begin
    sel_in[0]  = src0_sel;
    sel_in[1]  = src1_sel;
    data_in[0] = src0_data;
    data_in[1] = src1_data;
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      assign ready[gi]    = (cnt_q[gi] != CNT_W'(DEPTH));
      assign nonempty[gi] = (cnt_q[gi] != '0);
      assign push[gi]     = valid_in[gi] & ready[gi] & ~flush;
      assign pop[gi]      = grant_any & (grant_src == 1'(gi)) & ~flush;
    end
  endgenerate

  // last_q names the source granted on the most recent tie; the other one wins the next tie.
  always_comb begin
    grant_any = |nonempty;
    grant_src = nonempty[1] & (~nonempty[0] | ~last_q);
    last_d    = (&nonempty && !flush) ? grant_src : last_q;
    for (int s = 0; s < 2; s++) begin
      head_sel[s]  = sel_mem_q[s][rd_ptr_q[s]];
      head_data[s] = data_mem_q[s][rd_ptr_q[s]];
      cnt_d[s]     = flush ? '0 : cnt_q[s] + CNT_W'(push[s]) - CNT_W'(pop[s]);
      rd_ptr_d[s]  = flush ? '0 : rd_ptr_q[s] + PTR_W'(pop[s]);
      wr_ptr_d[s]  = flush ? '0 : wr_ptr_q[s] + PTR_W'(push[s]);
    end
    wr_load_d = grant_any & ~flush;
    wr_sel_d  = wr_load_d ? head_sel[grant_src]  : wr_sel_q;
    wr_data_d = wr_load_d ? head_data[grant_src] : wr_data_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < 2; s++) begin
        cnt_q[s]    <= '0;
        rd_ptr_q[s] <= '0;
        wr_ptr_q[s] <= '0;
      end
      last_q    <= 1'b1;
      wr_load_q <= 1'b0;
      wr_sel_q  <= '0;
      wr_data_q <= '0;
    end else begin
      for (int s = 0; s < 2; s++) begin
        cnt_q[s]    <= cnt_d[s];
        rd_ptr_q[s] <= rd_ptr_d[s];
        wr_ptr_q[s] <= wr_ptr_d[s];
      end
      last_q    <= last_d;
      wr_load_q <= wr_load_d;
      wr_sel_q  <= wr_sel_d;
      wr_data_q <= wr_data_d;
    end
  end

  // Entry storage carries no reset; only slots inside the count are ever observed.
  always_ff @(posedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (push[s]) begin
        sel_mem_q[s][wr_ptr_q[s]]  <= sel_in[s];
        data_mem_q[s][wr_ptr_q[s]] <= data_in[s];
      end
    end
  end

  // A slot is live when its distance from the read pointer is below the count.
  always_comb begin
    pending_v = '0;
    for (int s = 0; s < 2; s++) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (CNT_W'(PTR_W'(PTR_W'(k) - rd_ptr_q[s])) < cnt_q[s]) begin
          pending_v[sel_mem_q[s][k]] = 1'b1;
        end
      end
    end
    if (wr_load_q) begin
      pending_v[wr_sel_q] = 1'b1;
    end
  end

  assign src0_ready = ready[0];
  assign src1_ready = ready[1];
  assign wr_load    = wr_load_q;
  assign wr_sel     = wr_sel_q;
  assign wr_data    = wr_data_q;
  assign pending    = pending_v;
  assign idle       = ~nonempty[0] & ~nonempty[1] & ~wr_load_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: reset, latency, round-robin ties,
// back-pressure, flush and asynchronous reset, with hand-computed expectations.
module tb_regfile_wb_arbiter;
  logic        clk;
  logic        reset_n;
  logic        src0_valid, src0_ready;
  logic [2:0]  src0_sel;
  logic [15:0] src0_data;
  logic        src1_valid, src1_ready;
  logic [2:0]  src1_sel;
  logic [15:0] src1_data;
  logic        flush;
  logic        wr_load;
  logic [2:0]  wr_sel;
  logic [15:0] wr_data;
  logic [7:0]  pending;
  logic        idle;

  int checks = 0;
  int errors = 0;

  regfile_wb_arbiter #(.WIDTH(16), .NUM_REGS(8), .DEPTH(2)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .src0_valid (src0_valid),
    .src0_ready (src0_ready),
    .src0_sel   (src0_sel),
    .src0_data  (src0_data),
    .src1_valid (src1_valid),
    .src1_ready (src1_ready),
    .src1_sel   (src1_sel),
    .src1_data  (src1_data),
    .flush      (flush),
    .wr_load    (wr_load),
    .wr_sel     (wr_sel),
    .wr_data    (wr_data),
    .pending    (pending),
    .idle       (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // FIFO occupancy may never exceed DEPTH nor wrap below zero.
  always @(negedge clk) begin
    chk("cnt0_bound", 32'(dut.cnt_q[0] <= 2'd2), 32'd1);
    chk("cnt1_bound", 32'(dut.cnt_q[1] <= 2'd2), 32'd1);
  end

  initial begin
    int  i0, i1, k, idx;
    logic acc0, acc1, exp_load;
    logic [2:0]  exp_sel;
    logic [15:0] exp_data;

    reset_n = 1'b0;
    src0_valid = 0; src0_sel = 0; src0_data = 0;
    src1_valid = 0; src1_sel = 0; src1_data = 0;
    flush = 0;

    // 1: reset state
    repeat (3) step();
    reset_n = 1'b1;
    step();
    chk("rst_load", wr_load, 0);
    chk("rst_sel", wr_sel, 0);
    chk("rst_data", wr_data, 0);
    chk("rst_pending", pending, 8'h00);
    chk("rst_idle", idle, 1);
    chk("rst_rdy0", src0_ready, 1);
    chk("rst_rdy1", src1_ready, 1);

    // 2: single src0 write, latency and pending window
    src0_valid = 1; src0_sel = 3; src0_data = 16'h1234;
    step();
    src0_valid = 0;
    chk("t2_load_t", wr_load, 0);
    chk("t2_pend_t", pending, 8'h08);
    chk("t2_idle_t", idle, 0);
    step();
    chk("t2_load_t1", wr_load, 1);
    chk("t2_sel_t1", wr_sel, 3);
    chk("t2_data_t1", wr_data, 16'h1234);
    chk("t2_pend_t1", pending, 8'h08);
    step();
    chk("t2_load_t2", wr_load, 0);
    chk("t2_pend_t2", pending, 8'h00);
    chk("t2_idle_t2", idle, 1);
    chk("t2_sel_hold", wr_sel, 3);

    // 3: tie goes to src0 first, the next tie to src1
    src0_valid = 1; src0_sel = 1; src0_data = 16'hAAAA;
    src1_valid = 1; src1_sel = 2; src1_data = 16'h5555;
    step();
    src0_valid = 0; src1_valid = 0;
    chk("t3_pend", pending, 8'h06);
    step();
    chk("t3_w1_load", wr_load, 1);
    chk("t3_w1_sel", wr_sel, 1);
    chk("t3_w1_data", wr_data, 16'hAAAA);
    step();
    chk("t3_w2_load", wr_load, 1);
    chk("t3_w2_sel", wr_sel, 2);
    chk("t3_w2_data", wr_data, 16'h5555);
    step();
    chk("t3_idle", idle, 1);
    src0_valid = 1; src0_sel = 4; src0_data = 16'h0404;
    src1_valid = 1; src1_sel = 5; src1_data = 16'h0505;
    step();
    src0_valid = 0; src1_valid = 0;
    step();
    chk("t3_r1_sel", wr_sel, 5);
    chk("t3_r1_data", wr_data, 16'h0505);
    step();
    chk("t3_r2_sel", wr_sel, 4);
    chk("t3_r2_data", wr_data, 16'h0404);
    step();
    chk("t3_r_idle", idle, 1);

    // 4: both sources stream 6 entries each; src0 entry i -> R(i), src1 entry i -> R(7-i)
    i0 = 0; i1 = 0;
    for (int c = 1; c <= 15; c++) begin
      src0_valid = (i0 < 6); src0_sel = 3'(i0);     src0_data = 16'hA000 + 16'(i0);
      src1_valid = (i1 < 6); src1_sel = 3'(7 - i1); src1_data = 16'hB000 + 16'(i1);
      acc0 = src0_valid && src0_ready;
      acc1 = src1_valid && src1_ready;
      step();
      if (acc0) i0++;
      if (acc1) i1++;
      exp_load = (c >= 2 && c <= 13);
      chk("t4_load", wr_load, exp_load);
      if (exp_load) begin
        k = c - 2;
        idx = k / 2;
        if (k % 2 == 0) begin
          exp_sel = 3'(idx);     exp_data = 16'hA000 + 16'(idx);
        end else begin
          exp_sel = 3'(7 - idx); exp_data = 16'hB000 + 16'(idx);
        end
        $display("t4 write %0d sel=%0d data=%h", k, wr_sel, wr_data);
        chk("t4_sel", wr_sel, exp_sel);
        chk("t4_data", wr_data, exp_data);
      end
      if (c == 2) chk("t4_rdy1_full", src1_ready, 0);
      if (c == 3) chk("t4_rdy0_full", src0_ready, 0);
    end
    src0_valid = 0; src1_valid = 0;
    chk("t4_accepted", i0 + i1, 12);
    chk("t4_idle", idle, 1);

    // 5: flush with one write presented and two queued in src1
    src0_valid = 1; src0_sel = 7; src0_data = 16'h7777;
    src1_valid = 1; src1_sel = 6; src1_data = 16'h6666;
    step();
    src0_valid = 0; src1_sel = 5; src1_data = 16'h5555;
    step();
    chk("t5_b_sel", wr_sel, 6);
    chk("t5_b_pend", pending, 8'hE0);
    src1_sel = 4; src1_data = 16'h4444;
    step();
    chk("t5_c_load", wr_load, 1);
    chk("t5_c_sel", wr_sel, 7);
    chk("t5_c_data", wr_data, 16'h7777);
    chk("t5_c_pend", pending, 8'hB0);
    src1_valid = 0; flush = 1;
    src0_valid = 1; src0_sel = 3; src0_data = 16'h3333;
    step();
    flush = 0; src0_valid = 0;
    chk("t5_f_load", wr_load, 0);
    chk("t5_f_pend", pending, 8'h00);
    chk("t5_f_idle", idle, 1);
    chk("t5_f_rdy0", src0_ready, 1);
    chk("t5_f_rdy1", src1_ready, 1);
    repeat (3) begin
      step();
      chk("t5_no_write", wr_load, 0);
    end

    // 6: asynchronous reset between edges mid-burst
    src0_valid = 1; src0_sel = 2; src0_data = 16'h2222;
    src1_valid = 1; src1_sel = 3; src1_data = 16'h3333;
    step();
    src0_valid = 0; src1_sel = 4; src1_data = 16'h4444;
    step();
    src1_valid = 0;
    chk("t6_e2_sel", wr_sel, 3);
    step();
    chk("t6_e3_sel", wr_sel, 2);
    chk("t6_e3_pend", pending, 8'h14);
    #3 reset_n = 1'b0;
    #1;
    chk("t6_rst_load", wr_load, 0);
    chk("t6_rst_sel", wr_sel, 0);
    chk("t6_rst_pend", pending, 8'h00);
    chk("t6_rst_idle", idle, 1);
    #2 reset_n = 1'b1;
    src0_valid = 1; src0_sel = 1; src0_data = 16'h1111;
    src1_valid = 1; src1_sel = 2; src1_data = 16'h2222;
    step();
    src0_valid = 0; src1_valid = 0;
    chk("t6_pend", pending, 8'h06);
    step();
    chk("t6_w1_load", wr_load, 1);
    chk("t6_w1_sel", wr_sel, 1);
    chk("t6_w1_data", wr_data, 16'h1111);
    step();
    chk("t6_w2_sel", wr_sel, 2);
    chk("t6_w2_data", wr_data, 16'h2222);
    step();
    chk("t6_idle", idle, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
